imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction memory for the fetch stage, filled after reset through a byte-serial
// valid/ready load port. Optional image checksum is enabled by defining IMEM_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd128,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [31:0] ins_addr,
  output logic [31:0] ins_data,
  output logic        core_run,
  output logic        load_ovf,
  output logic        addr_err,
  output logic [31:0] checksum
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   shift_q, shift_d;
  logic          core_run_q, core_run_d;
  logic          load_ovf_q, load_ovf_d;
  logic          addr_err_q, addr_err_d;

  logic          fire_s;
  logic          wr_en_s;
  logic          last_slot_s;
  logic [31:0]   word_s;
  logic [31:0]   offset_s;
  logic          addr_ok_s;
  logic [AW-1:0] rd_idx_s;

  logic [31:0]   mem_q [DEPTH_WORDS];

  assign ld_ready    = (state_q == ST_LOAD);
  assign fire_s      = ld_valid & ld_ready;
  assign last_slot_s = (wptr_q == LAST_IDX);
  assign word_s      = shift_q | ({24'd0, ld_byte} << {byte_cnt_q, 3'b000});
  assign wr_en_s     = fire_s & ((byte_cnt_q == 2'd3) | ld_last);

  // Fetch address decode: word-aligned and inside the image window.
  assign offset_s  = ins_addr - BASE_ADDR;
  assign addr_ok_s = (offset_s[1:0] == 2'b00) && (offset_s[31:AW+2] == '0);
  assign rd_idx_s  = offset_s[AW+1:2];

  // Next-state logic for the load FSM and the sticky status flags.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wptr_d     = wptr_q;
    shift_d    = shift_q;
    core_run_d = core_run_q;
    load_ovf_d = load_ovf_q;
    addr_err_d = addr_err_q;
    if (fire_s) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (wr_en_s) begin
        // Clearing the shift register keeps unfilled upper bytes of a partial word at zero.
        shift_d = 32'd0;
        wptr_d  = last_slot_s ? wptr_q : (wptr_q + AW'(1));
        if (ld_last || last_slot_s) begin
          state_d    = ST_RUN;
          core_run_d = 1'b1;
        end else begin
          state_d    = state_q;
        end
        if (last_slot_s && !ld_last) begin
          load_ovf_d = 1'b1;
        end else begin
          load_ovf_d = load_ovf_q;
        end
      end else begin
        shift_d = word_s;
      end
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
    if ((state_q == ST_RUN) && !addr_ok_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_d;
    end
  end

  // Load FSM state and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= 2'd0;
      wptr_q     <= '0;
      shift_q    <= 32'd0;
      core_run_q <= 1'b0;
      load_ovf_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wptr_q     <= wptr_d;
      shift_q    <= shift_d;
      core_run_q <= core_run_d;
      load_ovf_q <= load_ovf_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Instruction storage; contents survive reset so stale words stay readable.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= word_s;
    end
  end

  // Combinational fetch port; NOP until the core is released or on a bad address.
  always_comb begin
    ins_data = NOP_WORD;
    if ((state_q == ST_RUN) && addr_ok_s) begin
      ins_data = mem_q[rd_idx_s];
    end else begin
      ins_data = NOP_WORD;
    end
  end

  assign core_run = core_run_q;
  assign load_ovf = load_ovf_q;
  assign addr_err = addr_err_q;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Running modulo-2^32 sum of every word committed to memory.
  always_comb begin
    if (wr_en_s) begin
      checksum_d = checksum_q + word_s;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= 32'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader (DEPTH_WORDS=4) against an
// image-level reference model.
module tb_imem_boot_loader;

  localparam int D = 4;
  localparam logic [31:0] BASE = 32'd128;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic [31:0] ins_addr;
  logic [31:0] ins_data;
  logic        core_run;
  logic        load_ovf;
  logic        addr_err;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_mem [D];
  bit          m_known [D];
  bit          m_run, m_ovf, m_err;
  logic [31:0] m_sum;

  imem_boot_loader #(.DEPTH_WORDS(D), .BASE_ADDR(BASE), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .ins_addr(ins_addr),
    .ins_data(ins_data), .core_run(core_run), .load_ovf(load_ovf),
    .addr_err(addr_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_checksum();
`ifdef IMEM_CHECKSUM_EN
    return m_sum;
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset();
    ld_valid = 1'b0; ld_byte = 8'd0; ld_last = 1'b0; ins_addr = BASE;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    m_run = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_sum = 32'd0;
  endtask

  // Image-level model: which words the image commits and where the load ends.
  task automatic model_image(input byte_q_t b, input bit has_last);
    int n, acc, hi;
    bit last_acc;
    logic [31:0] w;
    n = b.size();
    acc = (n < 4*D) ? n : 4*D;
    m_ovf = (n > 4*D) || (n == 4*D && !has_last);
    last_acc = has_last && (n <= 4*D);
    m_run = last_acc || m_ovf;
    for (int wi = 0; 4*wi < acc; wi++) begin
      hi = (4*wi + 4 < acc) ? 4*wi + 4 : acc;
      if ((hi - 4*wi == 4) || (last_acc && hi == acc)) begin
        w = 32'd0;
        for (int k = 0; k < hi - 4*wi; k++) w = w + ({24'd0, b[4*wi+k]} << (8*k));
        m_mem[wi] = w;
        m_known[wi] = 1'b1;
        m_sum = m_sum + w;
      end
    end
  endtask

  task automatic load_image(input byte_q_t b, input bit has_last, input int gap_at, input int gap_len);
    int n, acc;
    n = b.size();
    acc = (n < 4*D) ? n : 4*D;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) @(posedge clk);
        #1;
        check("core_run_in_gap", {31'd0, core_run}, 32'd0);
      end
      check("ld_ready_pre", {31'd0, ld_ready}, {31'd0, i < acc});
      ld_valid = 1'b1; ld_byte = b[i]; ld_last = has_last && (i == n - 1);
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
      if (i == acc - 1) model_image(b, has_last);
      if (i < acc - 1) check("core_run_loading", {31'd0, core_run}, 32'd0);
      if (i == acc - 1) begin
        check("core_run_after_last", {31'd0, core_run}, {31'd0, m_run});
        check("load_ovf_after_last", {31'd0, load_ovf}, {31'd0, m_ovf});
      end
    end
    if (n == 0) model_image(b, has_last);
    check("ld_ready_end", {31'd0, ld_ready}, {31'd0, !m_run});
    check("checksum", checksum, exp_checksum());
  endtask

  task automatic read_at(input logic [31:0] a);
    logic [31:0] off;
    bit ok;
    ins_addr = a;
    #1;
    off = a - BASE;
    ok = (off[1:0] == 2'b00) && ((off >> 2) < D);
    if (m_run && ok) begin
      if (m_known[off[3:2]]) check("ins_data", ins_data, m_mem[off[3:2]]);
    end else begin
      check("ins_data_nop", ins_data, NOP);
    end
    @(posedge clk); #1;
    if (m_run && !ok) m_err = 1'b1;
    check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
  endtask

  initial begin
    byte_q_t img;
    for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    reset_n = 1'b1;
    do_reset();
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_load_ovf", {31'd0, load_ovf}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    read_at(BASE);
    read_at(32'd3);

    // Two-instruction image
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load_image(img, 1'b1, -1, 0);
    ins_addr = 32'd128; #1 check("img1_w0", ins_data, 32'h0000_0013);
    ins_addr = 32'd132; #1 check("img1_w1", ins_data, 32'h0010_0093);
`ifdef IMEM_CHECKSUM_EN
    check("img1_checksum", checksum, 32'h0010_00A6);
`endif
    read_at(32'd128);
    read_at(32'd132);

    // Partial trailing word, with a gap between bytes 2 and 3
    do_reset();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_image(img, 1'b1, 2, 10);
    ins_addr = 32'd132; #1 check("partial_w1", ins_data, 32'h0000_00EE);
    ins_addr = 32'd128; #1 check("gap_w0", ins_data, 32'hDDCC_BBAA);
    read_at(32'd136);
    check("addr_err_in_range", {31'd0, addr_err}, 32'd0);

    // Overflow: 20 bytes, no ld_last
    do_reset();
    img = {};
    for (int i = 0; i < 20; i++) img.push_back(8'(8'h40 + i));
    load_image(img, 1'b0, -1, 0);
    check("ovf_flag", {31'd0, load_ovf}, 32'd1);
    check("ovf_core_run", {31'd0, core_run}, 32'd1);
    ins_addr = 32'd140; #1 check("ovf_w3", ins_data, 32'h4F4E_4D4C);
    read_at(32'd130);
    check("addr_err_sticky1", {31'd0, addr_err}, 32'd1);
    read_at(32'd124);
    read_at(32'd128 + 4*D);
    check("addr_err_sticky3", {31'd0, addr_err}, 32'd1);

    // Reset in the middle of a word, then a fresh one-word image
    do_reset();
    img = '{8'h77, 8'h66};
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_byte = img[i]; ld_last = 1'b0;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    do_reset();
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_image(img, 1'b1, -1, 0);
    ins_addr = 32'd128; #1 check("rst_mid_w0", ins_data, 32'h0403_0201);
    check("rst_mid_ovf", {31'd0, load_ovf}, 32'd0);
    read_at(32'd132);

    // Randomized images and fetches
    for (int it = 0; it < 8; it++) begin
      int len, gap_at;
      bit has_last;
      do_reset();
      len = $urandom_range(1, 19);
      has_last = (len <= 4*D) ? ($urandom_range(0, 3) != 0) : 1'b0;
      img = {};
      for (int i = 0; i < len; i++) img.push_back(8'($urandom_range(0, 255)));
      gap_at = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : -1;
      load_image(img, has_last, gap_at, $urandom_range(1, 6));
      for (int r = 0; r < 10; r++) begin
        read_at(BASE - 32'd8 + 32'($urandom_range(0, 4*D + 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
